// File: rtl/stack_xfer_seq.sv
// PSHS/PSHU/PULS/PULU register-list sequencer: walks the postbyte mask in 6809
// order, issues one byte access per handshake and writes the final pointer back.
module stack_xfer_seq #(
  parameter int ADDR_W = 16
) (
  input  logic              cpu_clk,
  input  logic              cpu_reset_n,
  input  logic              start,
  input  logic              is_pull,
  input  logic              use_s,
  input  logic [7:0]        reg_mask,
  input  logic [ADDR_W-1:0] sp_in,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata,
  input  logic [7:0]        reg_rdata,
  output logic              busy,
  output logic              done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic [3:0]        reg_sel,
  output logic              byte_hi,
  output logic              reg_we,
  output logic [7:0]        reg_wdata,
  output logic              sp_we,
  output logic [ADDR_W-1:0] sp_out
);

  typedef enum logic [1:0] {IDLE, XFER_HI, XFER_LO, FINISH} state_e;

  localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [7:0]        mask_q, mask_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              pull_q, pull_d;
  logic              use_s_q, use_s_d;
  logic [2:0]        cur_idx;
  logic [7:0]        mask_clr;
  logic              last_byte;
  logic              xfer;

  // Push serves the highest remaining bit first, pull the lowest.
  function automatic logic [2:0] pick(input logic [7:0] m, input logic pull);
    logic [2:0] idx;
    idx = 3'd0;
    if (pull) begin
      for (int i = 7; i >= 0; i--) if (m[i]) idx = 3'(i);
    end else begin
      for (int i = 0; i < 8; i++) if (m[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  function automatic state_e first_state(input logic [2:0] idx, input logic pull);
    return (idx[2] && pull) ? XFER_HI : XFER_LO;
  endfunction

  function automatic logic [3:0] sel_code(input logic [2:0] idx, input logic us);
    logic [3:0] code;
    case (idx)
      3'd0:    code = 4'hA;
      3'd1:    code = 4'h8;
      3'd2:    code = 4'h9;
      3'd3:    code = 4'hB;
      3'd4:    code = 4'h1;
      3'd5:    code = 4'h2;
      3'd6:    code = us ? 4'h3 : 4'h4;
      default: code = 4'h5;
    endcase
    return code;
  endfunction

  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    ptr_d    = ptr_q;
    pull_d   = pull_q;
    use_s_d  = use_s_q;
    cur_idx  = pick(mask_q, pull_q);
    mask_clr = mask_q & ~(8'd1 << cur_idx);
    // 16-bit push ends on the high byte; pulls and 8-bit registers end on the low byte.
    last_byte = (state_q == XFER_HI) ? !pull_q : (pull_q || !cur_idx[2]);
    case (state_q)
      IDLE: begin
        if (start) begin
          mask_d  = reg_mask;
          pull_d  = is_pull;
          use_s_d = use_s;
          ptr_d   = sp_in;
          state_d = (reg_mask == 8'h00) ? FINISH
                                        : first_state(pick(reg_mask, is_pull), is_pull);
        end
      end
      XFER_HI, XFER_LO: begin
        if (mem_ack) begin
          ptr_d = pull_q ? ptr_q + PTR_ONE : ptr_q - PTR_ONE;
          if (last_byte) begin
            mask_d  = mask_clr;
            state_d = (mask_clr == 8'h00) ? FINISH
                                          : first_state(pick(mask_clr, pull_q), pull_q);
          end else begin
            state_d = (state_q == XFER_HI) ? XFER_LO : XFER_HI;
          end
        end
      end
      FINISH: begin
        state_d = IDLE;
        mask_d  = 8'h00;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge cpu_clk) begin
    if (!cpu_reset_n) begin
      state_q <= IDLE;
      mask_q  <= 8'h00;
      ptr_q   <= '0;
      pull_q  <= 1'b0;
      use_s_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      ptr_q   <= ptr_d;
      pull_q  <= pull_d;
      use_s_q <= use_s_d;
    end
  end

  // Outputs decode registered state only, so they hold steady across mem_ack stalls.
  assign xfer      = (state_q == XFER_HI) || (state_q == XFER_LO);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == FINISH);
  assign sp_we     = (state_q == FINISH);
  assign sp_out    = (state_q == FINISH) ? ptr_q : '0;
  assign mem_req   = xfer;
  assign mem_we    = xfer && !pull_q;
  assign mem_addr  = xfer ? (pull_q ? ptr_q : ptr_q - PTR_ONE) : '0;
  assign reg_sel   = xfer ? sel_code(cur_idx, use_s_q) : 4'h0;
  assign byte_hi   = (state_q == XFER_HI);
  assign reg_we    = xfer && pull_q && mem_ack;
  assign reg_wdata = (xfer && pull_q) ? mem_rdata : 8'h00;
  assign mem_wdata = (xfer && !pull_q) ? reg_rdata : 8'h00;

endmodule

// File: tb/tb_stack_xfer_seq.sv
// Directed bench for stack_xfer_seq: push/pull orders, pointer wrap, empty mask,
// stalls and mid-transfer reset.
module tb_stack_xfer_seq;
  logic        cpu_clk = 1'b0;
  logic        cpu_reset_n, start, is_pull, use_s, mem_ack;
  logic [7:0]  reg_mask, mem_rdata, reg_rdata;
  logic [15:0] sp_in;
  logic        busy, done, mem_req, mem_we, byte_hi, reg_we, sp_we;
  logic [15:0] mem_addr, sp_out;
  logic [7:0]  mem_wdata, reg_wdata;
  logic [3:0]  reg_sel;
  int checks = 0;
  int failures = 0;

  always #5 cpu_clk = ~cpu_clk;

  // Register file model: byte value identifies register and half.
  assign reg_rdata = {reg_sel, 3'b000, byte_hi};

  stack_xfer_seq #(.ADDR_W(16)) dut (
    .cpu_clk(cpu_clk), .cpu_reset_n(cpu_reset_n), .start(start), .is_pull(is_pull),
    .use_s(use_s), .reg_mask(reg_mask), .sp_in(sp_in), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .reg_rdata(reg_rdata), .busy(busy), .done(done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .reg_sel(reg_sel), .byte_hi(byte_hi), .reg_we(reg_we), .reg_wdata(reg_wdata),
    .sp_we(sp_we), .sp_out(sp_out));

  task automatic step();
    @(posedge cpu_clk); #1;
  endtask

  // Called in cycle T; returns in cycle T+1.
  task automatic kick(input logic pull, input logic us, input logic [7:0] m,
                      input logic [15:0] sp);
    is_pull = pull; use_s = us; reg_mask = m; sp_in = sp; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    cpu_reset_n = 1'b0; start = 1'b0; is_pull = 1'b0; use_s = 1'b0;
    reg_mask = 8'h00; sp_in = 16'h0000; mem_ack = 1'b1; mem_rdata = 8'h00;
    step(); step();
    checks++;
    if ({busy, done, mem_req, mem_we, reg_we, sp_we, byte_hi, reg_sel, mem_addr, sp_out,
         mem_wdata, reg_wdata} !== '0) begin
      failures++;
      $display("FAIL reset_outputs busy=%b done=%b req=%b addr=%h sp_out=%h sel=%h expected all zero",
               busy, done, mem_req, mem_addr, sp_out, reg_sel);
    end
    cpu_reset_n = 1'b1;
    step();
  endtask

  task automatic test_push_s_all();
    logic [3:0] sel[12] = '{4'h5, 4'h5, 4'h3, 4'h3, 4'h2, 4'h2, 4'h1, 4'h1,
                            4'hB, 4'h9, 4'h8, 4'hA};
    logic hi;
    kick(1'b0, 1'b1, 8'hFF, 16'h1000);
    for (int i = 0; i < 12; i++) begin
      hi = (i < 8) ? ((i % 2) == 1) : 1'b0;
      checks++;
      if ({busy, mem_req, mem_we, reg_we, done} !== 5'b11100 || mem_addr !== 16'h0FFF - 16'(i)
          || reg_sel !== sel[i] || byte_hi !== hi || mem_wdata !== {sel[i], 3'b000, hi}) begin
        failures++;
        $display("FAIL pshs_byte%0d addr=%h sel=%h hi=%b wdata=%h req=%b we=%b expected addr=%h sel=%h hi=%b",
                 i, mem_addr, reg_sel, byte_hi, mem_wdata, mem_req, mem_we,
                 16'h0FFF - 16'(i), sel[i], hi);
      end
      start = (i == 1);
      reg_mask = 8'h00;
      step();
      start = 1'b0;
    end
    checks++;
    if (done !== 1'b1 || sp_we !== 1'b1 || sp_out !== 16'h0FF4 || mem_req !== 1'b0) begin
      failures++;
      $display("FAIL pshs_finish done=%b sp_we=%b sp_out=%h req=%b expected 1 1 0ff4 0",
               done, sp_we, sp_out, mem_req);
    end
    step();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL pshs_idle busy=%b done=%b expected 0 0", busy, done);
    end
  endtask

  task automatic test_pull_s();
    logic [3:0]  sel[3]  = '{4'hA, 4'h5, 4'h5};
    logic        hi[3]   = '{1'b0, 1'b1, 1'b0};
    logic [15:0] addr[3] = '{16'h0FF4, 16'h0FF5, 16'h0FF6};
    kick(1'b1, 1'b1, 8'h81, 16'h0FF4);
    for (int i = 0; i < 3; i++) begin
      mem_rdata = 8'hC0 + 8'(i);
      #1;
      checks++;
      if (mem_req !== 1'b1 || mem_we !== 1'b0 || reg_we !== 1'b1 || mem_addr !== addr[i]
          || reg_sel !== sel[i] || byte_hi !== hi[i] || reg_wdata !== 8'hC0 + 8'(i)) begin
        failures++;
        $display("FAIL puls_byte%0d addr=%h sel=%h hi=%b reg_we=%b wdata=%h expected addr=%h sel=%h hi=%b",
                 i, mem_addr, reg_sel, byte_hi, reg_we, reg_wdata, addr[i], sel[i], hi[i]);
      end
      step();
    end
    mem_rdata = 8'h00;
    checks++;
    if (done !== 1'b1 || sp_we !== 1'b1 || sp_out !== 16'h0FF7) begin
      failures++;
      $display("FAIL puls_finish done=%b sp_we=%b sp_out=%h expected 1 1 0ff7", done, sp_we, sp_out);
    end
    step();
  endtask

  task automatic test_push_u_s_reg();
    kick(1'b0, 1'b0, 8'h40, 16'h2000);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 16'h1FFF - 16'(i)
          || reg_sel !== 4'h4 || byte_hi !== (i == 1)) begin
        failures++;
        $display("FAIL pshu_byte%0d addr=%h sel=%h hi=%b expected addr=%h sel=4",
                 i, mem_addr, reg_sel, byte_hi, 16'h1FFF - 16'(i));
      end
      step();
    end
    checks++;
    if (done !== 1'b1 || sp_out !== 16'h1FFE) begin
      failures++;
      $display("FAIL pshu_finish done=%b sp_out=%h expected 1 1ffe", done, sp_out);
    end
    step();
  endtask

  task automatic test_empty_mask();
    kick(1'b0, 1'b1, 8'h00, 16'h1234);
    checks++;
    if (mem_req !== 1'b0 || done !== 1'b1 || sp_we !== 1'b1 || sp_out !== 16'h1234) begin
      failures++;
      $display("FAIL empty_mask req=%b done=%b sp_we=%b sp_out=%h expected 0 1 1 1234",
               mem_req, done, sp_we, sp_out);
    end
    step();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL empty_idle busy=%b expected 0", busy);
    end
  endtask

  task automatic test_wrap();
    kick(1'b0, 1'b1, 8'h02, 16'h0000);
    checks++;
    if (mem_addr !== 16'hFFFF || reg_sel !== 4'h8 || mem_we !== 1'b1) begin
      failures++;
      $display("FAIL wrap_push addr=%h sel=%h we=%b expected ffff 8 1", mem_addr, reg_sel, mem_we);
    end
    step();
    checks++;
    if (done !== 1'b1 || sp_out !== 16'hFFFF) begin
      failures++;
      $display("FAIL wrap_push_sp done=%b sp_out=%h expected 1 ffff", done, sp_out);
    end
    step();
    kick(1'b1, 1'b1, 8'h04, 16'hFFFF);
    checks++;
    if (mem_addr !== 16'hFFFF || reg_sel !== 4'h9 || mem_we !== 1'b0) begin
      failures++;
      $display("FAIL wrap_pull addr=%h sel=%h we=%b expected ffff 9 0", mem_addr, reg_sel, mem_we);
    end
    step();
    checks++;
    if (done !== 1'b1 || sp_out !== 16'h0000) begin
      failures++;
      $display("FAIL wrap_pull_sp done=%b sp_out=%h expected 1 0000", done, sp_out);
    end
    step();
  endtask

  task automatic test_backpressure();
    kick(1'b1, 1'b1, 8'h30, 16'h3000);
    checks++;
    if (mem_addr !== 16'h3000 || reg_sel !== 4'h1 || byte_hi !== 1'b1) begin
      failures++;
      $display("FAIL stall_byte0 addr=%h sel=%h hi=%b expected 3000 1 1", mem_addr, reg_sel, byte_hi);
    end
    step();
    mem_ack = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) mem_ack = 1'b1;
      #1;
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 16'h3001 || reg_sel !== 4'h1 || byte_hi !== 1'b0
          || reg_we !== (c == 3)) begin
        failures++;
        $display("FAIL stall_hold%0d addr=%h sel=%h hi=%b reg_we=%b expected 3001 1 0",
                 c, mem_addr, reg_sel, byte_hi, reg_we);
      end
      step();
    end
    checks++;
    if (mem_addr !== 16'h3002 || reg_sel !== 4'h2 || byte_hi !== 1'b1) begin
      failures++;
      $display("FAIL stall_byte2 addr=%h sel=%h hi=%b expected 3002 2 1", mem_addr, reg_sel, byte_hi);
    end
    step(); step();
    checks++;
    if (done !== 1'b1 || sp_out !== 16'h3004) begin
      failures++;
      $display("FAIL stall_finish done=%b sp_out=%h expected 1 3004", done, sp_out);
    end
    step();
  endtask

  task automatic test_reset_mid();
    kick(1'b0, 1'b1, 8'hFF, 16'h1000);
    step(); step();
    cpu_reset_n = 1'b0;
    step();
    cpu_reset_n = 1'b1;
    checks++;
    if (busy !== 1'b0 || mem_req !== 1'b0 || done !== 1'b0 || sp_we !== 1'b0) begin
      failures++;
      $display("FAIL midreset busy=%b req=%b done=%b sp_we=%b expected 0 0 0 0",
               busy, mem_req, done, sp_we);
    end
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (done !== 1'b0 || sp_we !== 1'b0 || mem_req !== 1'b0) begin
        failures++;
        $display("FAIL midreset_quiet%0d done=%b sp_we=%b req=%b expected 0 0 0",
                 c, done, sp_we, mem_req);
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    kick(1'b0, 1'b1, 8'h02, 16'h1000);
    checks++;
    if (mem_addr !== 16'h0FFF || reg_sel !== 4'h8 || mem_req !== 1'b1) begin
      failures++;
      $display("FAIL restart_byte addr=%h sel=%h req=%b expected 0fff 8 1", mem_addr, reg_sel, mem_req);
    end
    step();
    checks++;
    if (done !== 1'b1 || sp_out !== 16'h0FFF) begin
      failures++;
      $display("FAIL restart_finish done=%b sp_out=%h expected 1 0fff", done, sp_out);
    end
    step();
    kick(1'b1, 1'b1, 8'h08, 16'h0FFF);
    checks++;
    if (mem_addr !== 16'h0FFF || reg_sel !== 4'hB || mem_we !== 1'b0) begin
      failures++;
      $display("FAIL b2b_pull addr=%h sel=%h we=%b expected 0fff b 0", mem_addr, reg_sel, mem_we);
    end
    step();
    checks++;
    if (done !== 1'b1 || sp_out !== 16'h1000) begin
      failures++;
      $display("FAIL b2b_finish done=%b sp_out=%h expected 1 1000", done, sp_out);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_push_s_all();
    test_pull_s();
    test_push_u_s_reg();
    test_empty_mask();
    test_wrap();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
